// File: rtl/sram_fetch_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_fetch_bridge
//
// Bridges a 32-bit CPU request/ack port onto a 16-bit asynchronous SRAM.
// After reset the SD boot loader owns the SRAM through a combinational
// pass-through and the CPU is held in reset. When boot_ready is seen the
// bridge hands the SRAM to the CPU, releases cpu_reset_n, and services CPU
// reads and writes as two 16-bit half-word accesses (low half first).
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   boot_ready                 boot loader finished (hand-off is sticky)
//   boot_address/data/write_n  boot loader SRAM port, passed straight through
//   cpu_req, cpu_we            request (held until cpu_ack), 1 = write
//   cpu_addr                   byte address, only [18:2] selects a word pair
//   cpu_wdata, cpu_be          write data (little-endian) and byte enables
//   cpu_rdata                  registered read data, held until the next read
//   cpu_ack                    one-cycle completion pulse
//   cpu_reset_n                CPU hold, low until the boot hand-off
//   sram_address               SRAM word address
//   sram_dq_out, sram_dq_oe    write data and drive enable (tristate is above)
//   sram_dq_in                 SRAM read data
//   sram_we_n/oe_n/ub_n/lb_n   SRAM strobes, active-low
// -----------------------------------------------------------------------------
module sram_fetch_bridge (
    input  logic        clk,
    input  logic        reset,

    input  logic        boot_ready,
    input  logic [17:0] boot_address,
    input  logic [15:0] boot_data,
    input  logic        boot_write_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_reset_n,

    output logic [17:0] sram_address,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_ACK
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Address driven in the previous cycle; replayed whenever the bus is idle
    // so the SRAM address lines do not toggle between accesses.
    logic [17:0] addr_hold_q;

    // Low half-word of a read, parked until the high half arrives.
    logic [15:0] rdata_lo_q;

    // A CPU word lives in two consecutive SRAM words; byte 0 is the low byte
    // of the even word, matching the layout the boot loader writes.
    logic [16:0] word_pair;
    logic [17:0] lo_word_addr;
    logic [17:0] hi_word_addr;

    assign word_pair    = cpu_addr[18:2];
    assign lo_word_addr = {word_pair, 1'b0};
    assign hi_word_addr = {word_pair, 1'b1};

    // Address bits outside the SRAM window simply wrap; they are not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:19], cpu_addr[1:0]};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default on
    // entry; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // Leaving BOOT is permanent: nothing returns here except reset,
            // so a later drop of boot_ready has no effect.
            S_BOOT:  if (boot_ready) state_d = S_IDLE;
            S_IDLE:  if (cpu_req)    state_d = cpu_we ? S_WR_LO : S_RD_LO;
            S_RD_LO: state_d = S_RD_HI;
            S_RD_HI: state_d = S_ACK;
            S_WR_LO: state_d = S_WR_HI;
            S_WR_HI: state_d = S_ACK;
            // Straight back to IDLE; a still-high cpu_req is picked up there
            // on the next edge, giving a four-cycle back-to-back cadence.
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_BOOT;
        endcase
    end

    // -------------------------------------------------------------------------
    // SRAM bus drive
    // -------------------------------------------------------------------------
    // All bus outputs decode the registered state, so an asynchronous reset
    // switches the bus to the boot pass-through immediately, mid-access.
    always_comb begin
        sram_address = addr_hold_q;
        sram_dq_out  = 16'h0000;
        sram_dq_oe   = 1'b0;
        sram_we_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_ub_n    = 1'b0;
        sram_lb_n    = 1'b0;

        unique case (state_q)
            S_BOOT: begin
                // Pure pass-through; the data bus is driven only while the
                // boot loader writes, so it never fights an SRAM output.
                sram_address = boot_address;
                sram_dq_out  = boot_data;
                sram_we_n    = boot_write_n;
                sram_dq_oe   = ~boot_write_n;
            end
            S_RD_LO: begin
                sram_address = lo_word_addr;
                sram_oe_n    = 1'b0;
            end
            S_RD_HI: begin
                sram_address = hi_word_addr;
                sram_oe_n    = 1'b0;
            end
            S_WR_LO: begin
                sram_address = lo_word_addr;
                sram_dq_out  = cpu_wdata[15:0];
                sram_dq_oe   = 1'b1;
                sram_we_n    = 1'b0;
                sram_lb_n    = ~cpu_be[0];
                sram_ub_n    = ~cpu_be[1];
            end
            S_WR_HI: begin
                sram_address = hi_word_addr;
                sram_dq_out  = cpu_wdata[31:16];
                sram_dq_oe   = 1'b1;
                sram_we_n    = 1'b0;
                sram_lb_n    = ~cpu_be[2];
                sram_ub_n    = ~cpu_be[3];
            end
            default: begin
                // IDLE and ACK keep the quiet bus levels set above.
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // CPU side
    // -------------------------------------------------------------------------
    assign cpu_ack     = (state_q == S_ACK);
    assign cpu_reset_n = (state_q != S_BOOT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata   <= 32'h0000_0000;
            addr_hold_q <= 18'h0_0000;
        end else begin
            addr_hold_q <= sram_address;
            // Only a completed read updates cpu_rdata; writes leave the last
            // read value in place.
            if (state_q == S_RD_HI) begin
                cpu_rdata <= {sram_dq_in, rdata_lo_q};
            end
        end
    end

    // NOTE: pure datapath staging is left without reset; it is always written
    // in RD_LO before RD_HI consumes it, so its power-up value is never seen.
    always_ff @(posedge clk) begin
        if (state_q == S_RD_LO) begin
            rdata_lo_q <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_sram_fetch_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_fetch_bridge
//
// Directed plus randomized bench for sram_fetch_bridge. A behavioural SRAM
// sits on the bus; a transaction-level reference memory (16-bit words,
// updated byte-wise by each CPU write) supplies every expected read value.
// Inputs are driven 1 ns after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_sram_fetch_bridge;

    logic        clk;
    logic        reset;
    logic        boot_ready;
    logic [17:0] boot_address;
    logic [15:0] boot_data;
    logic        boot_write_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_reset_n;
    logic [17:0] sram_address;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    sram_fetch_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .boot_ready   (boot_ready),
        .boot_address (boot_address),
        .boot_data    (boot_data),
        .boot_write_n (boot_write_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_be       (cpu_be),
        .cpu_rdata    (cpu_rdata),
        .cpu_ack      (cpu_ack),
        .cpu_reset_n  (cpu_reset_n),
        .sram_address (sram_address),
        .sram_dq_out  (sram_dq_out),
        .sram_dq_oe   (sram_dq_oe),
        .sram_dq_in   (sram_dq_in),
        .sram_we_n    (sram_we_n),
        .sram_oe_n    (sram_oe_n),
        .sram_ub_n    (sram_ub_n),
        .sram_lb_n    (sram_lb_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: output only while oe_n is low (a marker otherwise),
    // byte-lane writes on the rising edge while we_n is low and the bus driven.
    logic [15:0] sram_mem [0:262143];

    assign sram_dq_in = sram_oe_n ? 16'hDEAD : sram_mem[sram_address];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) sram_mem[sram_address][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) sram_mem[sram_address][15:8] <= sram_dq_out[15:8];
        end
    end

    // Reference: the first 64 SRAM words as the CPU should see them.
    logic [15:0] ref_mem [0:63];
    logic [31:0] last_read;

    int n_pass;
    int n_total;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one cycle; the data bus must never be driven while the SRAM
    // output is enabled.
    task automatic step();
        @(posedge clk);
        #1;
        check("oe_conflict", 32'(sram_dq_oe & ~sram_oe_n), 32'd0);
    endtask

    // One CPU access launched just after an edge N; ack expected after N+3.
    // Only addresses with cpu_addr[18:2] < 32 are used so the reference
    // memory covers them.
    task automatic cpu_access(input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        int          idx;
        logic [31:0] exp;
        idx       = int'(addr[18:2]) * 2;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        for (int half = 0; half < 2; half++) begin
            step();
            check("half_addr", 32'(sram_address), 32'(idx + half));
            check("ack_early", 32'(cpu_ack), 32'd0);
            if (we) begin
                check("wr_we_n", 32'(sram_we_n), 32'd0);
                check("wr_dq_oe", 32'(sram_dq_oe), 32'd1);
                check("wr_oe_n", 32'(sram_oe_n), 32'd1);
                check("wr_dq_out", 32'(sram_dq_out), 32'((wdata >> (16 * half)) & 32'hFFFF));
                check("wr_lb_n", 32'(sram_lb_n), 32'(~be[2 * half] & 1'b1));
                check("wr_ub_n", 32'(sram_ub_n), 32'(~be[2 * half + 1] & 1'b1));
            end else begin
                check("rd_oe_n", 32'(sram_oe_n), 32'd0);
                check("rd_we_n", 32'(sram_we_n), 32'd1);
                check("rd_dq_oe", 32'(sram_dq_oe), 32'd0);
            end
        end
        step();
        check("ack", 32'(cpu_ack), 32'd1);
        if (we) begin
            check("rdata_held", cpu_rdata, last_read);
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    if (b % 2 == 0) ref_mem[idx + b / 2][7:0]  = wdata[8 * b +: 8];
                    else            ref_mem[idx + b / 2][15:8] = wdata[8 * b +: 8];
                end
            end
        end else begin
            exp = {ref_mem[idx + 1], ref_mem[idx]};
            check("rdata", cpu_rdata, exp);
            last_read = exp;
        end
        cpu_req = 1'b0;
        step();
        check("ack_one_cycle", 32'(cpu_ack), 32'd0);
    endtask

    initial begin
        logic [15:0] img;
        logic [31:0] r_addr;
        n_pass       = 0;
        n_total      = 0;
        last_read    = 32'h0;
        reset        = 1'b1;
        boot_ready   = 1'b0;
        boot_address = 18'd7;
        boot_data    = 16'h0000;
        boot_write_n = 1'b1;
        cpu_req      = 1'b0;
        cpu_we       = 1'b0;
        cpu_addr     = 32'h0;
        cpu_wdata    = 32'h0;
        cpu_be       = 4'h0;

        // Reset state, with the boot pass-through already live.
        step();
        check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_passthru_addr", 32'(sram_address), 32'd7);
        check("rst_passthru_we_n", 32'(sram_we_n), 32'd1);
        step();
        reset = 1'b0;

        // Boot pass-through.
        boot_address = 18'd5;
        boot_data    = 16'hBEEF;
        boot_write_n = 1'b0;
        #1;
        check("boot_addr", 32'(sram_address), 32'd5);
        check("boot_dq_out", 32'(sram_dq_out), 32'h0000_BEEF);
        check("boot_we_n", 32'(sram_we_n), 32'd0);
        check("boot_dq_oe", 32'(sram_dq_oe), 32'd1);
        check("boot_oe_n", 32'(sram_oe_n), 32'd1);
        check("boot_ub_lb", 32'({sram_ub_n, sram_lb_n}), 32'd0);
        check("boot_cpu_reset_n", 32'(cpu_reset_n), 32'd0);

        // CPU requests are ignored in BOOT.
        cpu_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("boot_no_ack", 32'(cpu_ack), 32'd0);
            check("boot_hold_cpu", 32'(cpu_reset_n), 32'd0);
        end
        cpu_req = 1'b0;

        // Boot image: words 2/3 fixed, the rest random.
        for (int i = 0; i < 64; i++) begin
            if (i == 2)      img = 16'h5678;
            else if (i == 3) img = 16'h1234;
            else             img = 16'($urandom);
            ref_mem[i]   = img;
            boot_address = 18'(i);
            boot_data    = img;
            boot_write_n = 1'b0;
            step();
            boot_write_n = 1'b1;
            step();
        end

        // Hand-off: one-cycle boot_ready pulse, sticky afterwards.
        boot_address = 18'h155;
        boot_ready   = 1'b1;
        step();
        check("handoff_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
        boot_ready = 1'b0;
        step();
        check("handoff_sticky", 32'(cpu_reset_n), 32'd1);
        boot_address = 18'h2AA;
        boot_write_n = 1'b0;
        #1;
        check("post_boot_we_n", 32'(sram_we_n), 32'd1);
        check("post_boot_dq_oe", 32'(sram_dq_oe), 32'd0);
        check("idle_addr_hold", 32'(sram_address), 32'h155);
        step();
        check("post_boot_we_n_edge", 32'(sram_we_n), 32'd1);
        check("idle_strobes", 32'({sram_oe_n, sram_ub_n, sram_lb_n}), 32'b100);
        boot_write_n = 1'b1;

        // Directed read of words 2/3.
        cpu_access(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        check("read_const", cpu_rdata, 32'h1234_5678);
        check("idle_addr_after_read", 32'(sram_address), 32'd3);

        // Write with partial byte enables, then read it back.
        cpu_access(1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0110);
        cpu_access(1'b0, 32'h0000_0008, 32'h0, 4'h0);

        // Write with no byte enables still completes and changes nothing.
        cpu_access(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
        cpu_access(1'b0, 32'h0000_0010, 32'h0, 4'h0);

        // Wrapped address, back-to-back reads: acks every fourth cycle.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h8000_0004;
        for (int k = 1; k <= 11; k++) begin
            step();
            check("b2b_ack", 32'(cpu_ack), 32'(k % 4 == 3));
            if (k % 4 == 3) check("b2b_rdata", cpu_rdata, {ref_mem[3], ref_mem[2]});
            if (k == 11) cpu_req = 1'b0;
        end
        last_read = {ref_mem[3], ref_mem[2]};
        step();
        check("b2b_end_ack", 32'(cpu_ack), 32'd0);
        step();
        check("b2b_no_restart", 32'({cpu_ack, sram_oe_n}), 32'b01);

        // Randomized traffic against the reference memory.
        for (int t = 0; t < 40; t++) begin
            r_addr       = $urandom;
            r_addr[18:2] = 17'($urandom_range(0, 31));
            cpu_access(1'($urandom_range(0, 1)), r_addr, $urandom, 4'($urandom));
        end

        // Reset during RD_HI aborts the read.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h0000_000C;
        step();
        step();
        boot_address = 18'h100;
        boot_data    = 16'h0F0F;
        boot_write_n = 1'b0;
        reset        = 1'b1;
        #1;
        check("abort_ack", 32'(cpu_ack), 32'd0);
        check("abort_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("abort_rdata", cpu_rdata, 32'd0);
        check("abort_we_n", 32'(sram_we_n), 32'd0);
        check("abort_addr", 32'(sram_address), 32'h100);
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_no_ack", 32'(cpu_ack), 32'd0);
        end
        reset        = 1'b0;
        boot_write_n = 1'b1;
        #1;
        check("abort_we_n_follow", 32'(sram_we_n), 32'd1);
        step();
        check("abort_still_boot", 32'(cpu_reset_n), 32'd0);
        boot_ready = 1'b1;
        step();
        boot_ready = 1'b0;
        check("reboot_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
        last_read = 32'h0;
        cpu_access(1'b0, 32'h0000_000C, 32'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
